updown_trace_decoder: RTL and testbench

Receive-side decoder for the 2-bit up/down counter FSM. It watches the counter's state trace `q` sample by sample and recovers the direction input `x` that produced each step. It regenerates the FSM's `out` indication: a down step from count 1 to count 0. It also flags illegal transitions and tracks run length. It sits on the observation side of the counter block and lets a checker or downstream logic read back the direction stream without access to `x`.

---
 rtl/updown_trace_decoder.sv | 128 ++++++++++++
 tb/tb_updown_trace_decoder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/updown_trace_decoder.sv
// rtl/updown_trace_decoder.sv - recovers up/down direction from an observed counter state trace
module updown_trace_decoder #(
    parameter int WIDTH = 2,
    parameter int RUNW  = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             q_valid_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             err_clr_i,
    output logic             x_valid_o,
    output logic             x_o,
    output logic             zero_dn_o,
    output logic             dir_change_o,
    output logic [RUNW-1:0]  run_len_o,
    output logic             err_o,
    output logic             err_sticky_o
);

    localparam logic [0:0]       ST_EMPTY = 1'b0;
    localparam logic [0:0]       ST_TRACK = 1'b1;
    localparam logic [WIDTH-1:0] DELTA_UP = WIDTH'(1);
    localparam logic [WIDTH-1:0] DELTA_DN = '1;
    localparam logic [WIDTH-1:0] Q_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] Q_ZERO   = '0;
    localparam logic [RUNW-1:0]  RUN_ONE  = RUNW'(1);
    localparam logic [RUNW-1:0]  RUN_MAX  = '1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             x_valid_q, x_valid_d;
    logic             x_q, x_d;
    logic             zero_dn_q, zero_dn_d;
    logic             dir_change_q, dir_change_d;
    logic [RUNW-1:0]  run_len_q, run_len_d;
    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;
    logic             last_valid_q, last_valid_d;
    logic             last_dir_q, last_dir_d;

    logic [WIDTH-1:0] delta;
    logic             step_up;
    logic             step_dn;

    // Classify the step against the stored reference; modular subtraction makes wraps legal steps.
    always_comb begin
        delta   = q_i - prev_q;
        step_up = (delta == DELTA_UP);
        step_dn = (delta == DELTA_DN);
    end

    // Next-state decode: pulses default low, levels and history hold unless a sample arrives.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        x_valid_d    = 1'b0;
        x_d          = x_q;
        zero_dn_d    = 1'b0;
        dir_change_d = 1'b0;
        run_len_d    = run_len_q;
        err_d        = 1'b0;
        last_valid_d = last_valid_q;
        last_dir_d   = last_dir_q;
        if (q_valid_i) begin
            prev_d = q_i;
            if (state_q == ST_EMPTY) begin
                state_d = ST_TRACK;
            end else if (step_up || step_dn) begin
                x_valid_d    = 1'b1;
                x_d          = step_dn;
                zero_dn_d    = step_dn && (prev_q == Q_ONE) && (q_i == Q_ZERO);
                last_valid_d = 1'b1;
                last_dir_d   = step_dn;
                if (last_valid_q && (last_dir_q == step_dn)) begin
                    run_len_d = (run_len_q == RUN_MAX) ? RUN_MAX : run_len_q + RUN_ONE;
                end else begin
                    run_len_d    = RUN_ONE;
                    dir_change_d = last_valid_q;
                end
            end else begin
                // Hold or jump: the new sample becomes the resync reference.
                err_d        = 1'b1;
                run_len_d    = '0;
                last_valid_d = 1'b0;
            end
        end
        // A fresh error outranks a clear in the same cycle.
        err_sticky_d = err_d | (err_sticky_q & ~err_clr_i);
    end

    // Register all state and outputs; synchronous reset returns to EMPTY with everything cleared.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_EMPTY;
            prev_q       <= '0;
            x_valid_q    <= 1'b0;
            x_q          <= 1'b0;
            zero_dn_q    <= 1'b0;
            dir_change_q <= 1'b0;
            run_len_q    <= '0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            last_valid_q <= 1'b0;
            last_dir_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            x_valid_q    <= x_valid_d;
            x_q          <= x_d;
            zero_dn_q    <= zero_dn_d;
            dir_change_q <= dir_change_d;
            run_len_q    <= run_len_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            last_valid_q <= last_valid_d;
            last_dir_q   <= last_dir_d;
        end
    end

    assign x_valid_o    = x_valid_q;
    assign x_o          = x_q;
    assign zero_dn_o    = zero_dn_q;
    assign dir_change_o = dir_change_q;
    assign run_len_o    = run_len_q;
    assign err_o        = err_q;
    assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_updown_trace_decoder.sv
// tb/tb_updown_trace_decoder.sv - table-driven scoreboard bench for updown_trace_decoder
module tb_updown_trace_decoder;

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] q;
        logic       clr;
        logic       xv;
        logic       x;
        logic       zd;
        logic       dc;
        logic [7:0] run;
        logic       err;
        logic       st;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       q_valid = 1'b0;
    logic [1:0] q = 2'd0;
    logic       err_clr = 1'b0;
    logic       x_valid, x, zero_dn, dir_change, err, err_sticky;
    logic [7:0] run_len;
    logic       x_valid2, x2, zero_dn2, dir_change2, err2, err_sticky2;
    logic [1:0] run_len2;

    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    updown_trace_decoder #(.WIDTH(2), .RUNW(8)) dut (
        .clk_i(clk), .reset_i(reset), .q_valid_i(q_valid), .q_i(q), .err_clr_i(err_clr),
        .x_valid_o(x_valid), .x_o(x), .zero_dn_o(zero_dn), .dir_change_o(dir_change),
        .run_len_o(run_len), .err_o(err), .err_sticky_o(err_sticky)
    );

    updown_trace_decoder #(.WIDTH(2), .RUNW(2)) dut_sat (
        .clk_i(clk), .reset_i(reset), .q_valid_i(q_valid), .q_i(q), .err_clr_i(err_clr),
        .x_valid_o(x_valid2), .x_o(x2), .zero_dn_o(zero_dn2), .dir_change_o(dir_change2),
        .run_len_o(run_len2), .err_o(err2), .err_sticky_o(err_sticky2)
    );

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, expv);
        end
    endtask

    function automatic void add(input logic rst, input logic v, input logic [1:0] qq, input logic clr,
                                input logic xv, input logic xx, input logic zd, input logic dc,
                                input logic [7:0] run, input logic e, input logic st);
        vec_t r;
        r.rst = rst; r.v = v; r.q = qq; r.clr = clr;
        r.xv = xv; r.x = xx; r.zd = zd; r.dc = dc; r.run = run; r.err = e; r.st = st;
        vecs.push_back(r);
    endfunction

    task automatic drive(input logic rst, input logic v, input logic [1:0] qq, input logic clr);
        reset = rst; q_valid = v; q = qq; err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst v  q  clr  xv x zd dc run err st
        // up run with wrap
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0,   1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 2, 0,   1, 0, 0, 0, 2, 0, 0);
        add(0, 1, 3, 0,   1, 0, 0, 0, 3, 0, 0);
        add(0, 1, 0, 0,   1, 0, 0, 0, 4, 0, 0);
        // down run
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 3, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 2, 0,   1, 1, 0, 0, 1, 0, 0);
        add(0, 1, 1, 0,   1, 1, 0, 0, 2, 0, 0);
        add(0, 1, 0, 0,   1, 1, 1, 0, 3, 0, 0);
        add(0, 1, 3, 0,   1, 1, 0, 0, 4, 0, 0);
        // direction reversal
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0,   1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0,   1, 1, 1, 1, 1, 0, 0);
        add(0, 1, 1, 0,   1, 0, 0, 1, 1, 0, 0);
        // hold error, recovery, jump errors, clear priority
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0,   0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 2, 0,   1, 0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0,   0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 2, 0,   0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 2, 1,   0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // gaps
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 2, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 3, 0,   1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 3, 0,   0, 0, 0, 0, 1, 0, 0);
        // reset mid-stream
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0,   1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 2, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 3, 0,   1, 0, 0, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            vec_t e;
            exp_q.push_back(vecs[i]);
            drive(vecs[i].rst, vecs[i].v, vecs[i].q, vecs[i].clr);
            e = exp_q.pop_front();
            check("x_valid",    i, {7'd0, x_valid},    {7'd0, e.xv});
            check("x",          i, {7'd0, x},          {7'd0, e.x});
            check("zero_dn",    i, {7'd0, zero_dn},    {7'd0, e.zd});
            check("dir_change", i, {7'd0, dir_change}, {7'd0, e.dc});
            check("run_len",    i, run_len,            e.run);
            check("err",        i, {7'd0, err},        {7'd0, e.err});
            check("err_sticky", i, {7'd0, err_sticky}, {7'd0, e.st});
        end

        // saturation: six up steps, narrow run counter clamps at 3
        drive(1, 0, 0, 0);
        check("sat_reset_run", 0, {6'd0, run_len2}, 8'd0);
        drive(0, 1, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            drive(0, 1, 2'(k % 4), 0);
            check("sat_xv",      k, {7'd0, x_valid2}, 8'd1);
            check("sat_run2",    k, {6'd0, run_len2}, (k > 3) ? 8'd3 : 8'(k));
            check("sat_run8",    k, run_len,          8'(k));
            check("sat_no_err",  k, {7'd0, err2},     8'd0);
        end

        drive(0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
